tx_sample_feeder: RTL
=====================

TX_SAMPLE_FEEDER -- requirements
Module: tx_sample_feeder

Interface
REQ-001 The module SHALL have parameter RATIO, default 12: output cycles per accepted sample (hold length), 2..15.
REQ-002 The module SHALL have parameter DATA_W, default 12: width of each I and Q sample, two's complement.
REQ-003 The module SHALL have parameter IDLE_LIMIT, default 16: consecutive missed samples before returning to IDLE, 1..255.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 AD9361_CLK  input  1  sole clock; all logic rising-edge.
REQ-006 rst_AD9361  input  1  asynchronous active-high reset.
REQ-007 enable  input  1  synchronous run enable.
REQ-008 s_axis_tvalid  input  1  FIFO-side sample valid.
REQ-009 s_axis_tready  output  1  sample accept strobe.
REQ-010 s_axis_tdata  input  2*DATA_W  sample, {Q, I}, with I in the low half.
REQ-011 tx_I  output  DATA_W  held I sample to AD9361 TX port.
REQ-012 tx_Q  output  DATA_W  held Q sample to AD9361 TX port.
REQ-013 tx_active  output  1  high in RUN or UNDERRUN.
REQ-014 underrun_pulse  output  1  one-cycle strobe per missed sample.
REQ-015 underrun_cnt  output  16  saturating count of missed samples.

Function
REQ-016 The phase counter SHALL count 0..RATIO-1 and wrap to 0 while enable=1; it SHALL be forced to 0 while enable=0.
REQ-017 s_axis_tready SHALL equal enable AND (phase==RATIO-1), combinationally, in every state.
REQ-018 A handshake SHALL be tvalid AND tready in the same cycle; no other cycle consumes data.
REQ-019 On a handshake, tx_I/tx_Q SHALL load tdata on that clock edge and hold it for exactly RATIO cycles (latency 1 cycle).
REQ-020 The FSM SHALL have states IDLE, RUN and UNDERRUN.
REQ-021 IDLE: outputs zero; on a handshake, load the sample and go to RUN; a miss in IDLE SHALL NOT pulse or count.
REQ-022 RUN: on a handshake, load the sample; on a miss (phase==RATIO-1, tvalid=0), zero the outputs, pulse underrun_pulse, clear miss_cnt to 1 and go to UNDERRUN.
REQ-023 UNDERRUN: on a handshake, load the sample, clear miss_cnt to 0 and go to RUN.
REQ-024 UNDERRUN: on a miss, pulse underrun_pulse and increment miss_cnt; when the incremented value equals IDLE_LIMIT, go to IDLE.
REQ-025 underrun_cnt SHALL increment on every underrun_pulse and saturate at 16'hFFFF.
REQ-026 enable 1->0 SHALL, on the next edge, force IDLE, phase 0, tx_I=tx_Q=0 and miss_cnt 0; underrun_cnt SHALL be retained.
REQ-027 tdata SHALL NOT be sampled in any cycle without a handshake; data after a gap SHALL NOT be replayed.

Reset
REQ-028 Assertion of rst_AD9361 SHALL immediately set state IDLE, phase 0, miss_cnt 0, and set tx_I, tx_Q, underrun_cnt, underrun_pulse and tx_active to 0.
REQ-029 The module SHALL leave reset on the first clock edge after rst_AD9361 deasserts; that edge is phase 0.

Structure
REQ-030 The FSM state encoding and RATIO/IDLE_LIMIT defaults SHALL be defined in a shared package, sdr_if_pkg.
REQ-031 One sub-module, phase_counter (modulo-RATIO counter with a wrap flag), SHALL be instantiated.

Verification
REQ-032 Reset, enable=1, tvalid always 1, samples I=1..5: tready every 12th cycle; tx_I=1 for 12 cycles, then 2, and so on; tx_active=1.
REQ-033 Drop tvalid for one tready slot mid-stream: tx_I=tx_Q=0 for 12 cycles, one underrun_pulse, underrun_cnt=1, and a return to RUN on the next slot.
REQ-034 tvalid=0 for 16 slots after RUN: 16 pulses, underrun_cnt=16, then IDLE with tx_active=0; further misses add no count.
REQ-035 Preload underrun_cnt near 16'hFFFF through repeated underruns: the count stops at 16'hFFFF.
REQ-036 enable=0 mid-hold with tdata=0x7FF/0x800: outputs 0 and phase 0 next cycle; re-enable gives first tready at cycle RATIO-1.
REQ-037 Assert rst_AD9361 asynchronously mid-hold: outputs 0 before the next edge; the sequence resumes correctly after release.

Source files
------------

// File: rtl/sdr_if_pkg.sv
// Shared definitions for the AD9361 TX sample path: FSM encoding, default
// rates and a saturating counter helper.
package sdr_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_UNDERRUN = 2'd2
  } feeder_state_e;

  localparam int unsigned RATIO_DEFAULT      = 12;
  localparam int unsigned DATA_W_DEFAULT     = 12;
  localparam int unsigned IDLE_LIMIT_DEFAULT = 16;

  // RATIO is at most 15, so a 4-bit phase always suffices.
  localparam int unsigned PHASE_W = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Modulo-RATIO phase counter; held at zero while disabled, wrap_o marks the
// last phase of each period.
module phase_counter
  import sdr_if_pkg::*;
#(
  parameter int unsigned RATIO = RATIO_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(RATIO - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = '0;
    if (en_i && (phase_q != LAST)) begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign wrap_o = (phase_q == LAST);

endmodule

// File: rtl/tx_sample_feeder.sv
// Pulls one {Q,I} sample every RATIO clocks from a FIFO and holds it on the
// AD9361 TX port, zeroing the port and counting every missed sample slot.
module tx_sample_feeder
  import sdr_if_pkg::*;
#(
  parameter int unsigned RATIO      = RATIO_DEFAULT,
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned IDLE_LIMIT = IDLE_LIMIT_DEFAULT
) (
  input  logic                AD9361_CLK,
  input  logic                rst_AD9361,
  input  logic                enable,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  output logic [DATA_W-1:0]   tx_I,
  output logic [DATA_W-1:0]   tx_Q,
  output logic                tx_active,
  output logic                underrun_pulse,
  output logic [15:0]         underrun_cnt
);

  localparam logic [7:0] LIMIT = 8'(IDLE_LIMIT);

  feeder_state_e     state_q, state_d;
  logic [7:0]        miss_q, miss_d;
  logic [DATA_W-1:0] tx_i_q, tx_i_d;
  logic [DATA_W-1:0] tx_q_q, tx_q_d;
  logic              pulse_q, pulse_d;
  logic [15:0]       cnt_q, cnt_d;

  logic slot;
  logic hs;
  logic miss;

  phase_counter #(
    .RATIO (RATIO)
  ) u_phase (
    .clk_i  (AD9361_CLK),
    .rst_i  (rst_AD9361),
    .en_i   (enable),
    .wrap_o (slot)
  );

  assign s_axis_tready = enable & slot;
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign miss          = s_axis_tready & ~s_axis_tvalid;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    tx_i_d  = tx_i_q;
    tx_q_d  = tx_q_q;
    pulse_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      miss_d  = '0;
      tx_i_d  = '0;
      tx_q_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (hs) begin
            tx_i_d  = s_axis_tdata[DATA_W-1:0];
            tx_q_d  = s_axis_tdata[2*DATA_W-1:DATA_W];
            miss_d  = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (hs) begin
            tx_i_d = s_axis_tdata[DATA_W-1:0];
            tx_q_d = s_axis_tdata[2*DATA_W-1:DATA_W];
          end else if (miss) begin
            tx_i_d  = '0;
            tx_q_d  = '0;
            pulse_d = 1'b1;
            miss_d  = 8'd1;
            // A limit of one means the first miss already exhausts the budget.
            state_d = (LIMIT == 8'd1) ? ST_IDLE : ST_UNDERRUN;
          end
        end
        ST_UNDERRUN: begin
          if (hs) begin
            tx_i_d  = s_axis_tdata[DATA_W-1:0];
            tx_q_d  = s_axis_tdata[2*DATA_W-1:DATA_W];
            miss_d  = '0;
            state_d = ST_RUN;
          end else if (miss) begin
            pulse_d = 1'b1;
            miss_d  = miss_q + 8'd1;
            if (miss_d == LIMIT) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          miss_d  = '0;
          tx_i_d  = '0;
          tx_q_d  = '0;
        end
      endcase
    end

    cnt_d = pulse_d ? sat_inc16(cnt_q) : cnt_q;
  end

  always_ff @(posedge AD9361_CLK or posedge rst_AD9361) begin
    if (rst_AD9361) begin
      state_q <= ST_IDLE;
      miss_q  <= '0;
      tx_i_q  <= '0;
      tx_q_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      tx_i_q  <= tx_i_d;
      tx_q_q  <= tx_q_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reads the live register so the async reset clears it without an edge.
  assign tx_active      = (state_q == ST_RUN) || (state_q == ST_UNDERRUN);
  assign tx_I           = tx_i_q;
  assign tx_Q           = tx_q_q;
  assign underrun_pulse = pulse_q;
  assign underrun_cnt   = cnt_q;

endmodule
